// File: rtl/trap_dump_pkg.sv
// ---- trap_dump_pkg | shared types/constants for trap_dump_unit | rev 1.0 ----
`default_nettype none

package trap_dump_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [31:0] TRAP_OPCODE_WORD = 32'h4400_0300;
    localparam int unsigned WORD_BYTES       = 4;

endpackage

`default_nettype wire

// File: rtl/trap_dump_unit.sv
// ---- trap_dump_unit | halts on trap word, streams DMEM result region | rev 1.0 ----
// ---- optional checksum trailer word: TRAP_DUMP_CHECKSUM_EN ----
`default_nettype none

module trap_dump_unit
    import trap_dump_pkg::*;
#(
    parameter logic [31:0] TRAP_WORD  = TRAP_OPCODE_WORD,
    parameter int unsigned DUMP_BASE  = 8192,
    parameter int unsigned DUMP_WORDS = 10,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        halt,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [31:0] dump_addr,
    output logic        dump_last,
    output logic        done
);

`ifdef TRAP_DUMP_CHECKSUM_EN
    localparam int unsigned TOTAL_WORDS = DUMP_WORDS + 1;
`else
    localparam int unsigned TOTAL_WORDS = DUMP_WORDS;
`endif
    localparam int unsigned LAST_IDX = (TOTAL_WORDS == 0) ? 0 : TOTAL_WORDS - 1;
    // Holds every index up to one past the checksum slot.
    localparam int CNT_W = $clog2(DUMP_WORDS + 2);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_cnt;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic [31:0]      dump_addr_q;
    logic [31:0]      sum;
    logic             halt_q;

    logic trap_seen;
    logic last_word;
    logic lat_done;
    logic handshake;
    logic ck_slot;

    assign trap_seen = instr_valid && (instruction == TRAP_WORD);
    assign last_word = (cnt == CNT_W'(LAST_IDX));
    assign lat_done  = (lat_cnt == 2'(MEM_LAT - 1));
    assign handshake = (state == SEND) && dump_ready;

`ifdef TRAP_DUMP_CHECKSUM_EN
    // The slot after the data words carries the running sum, not a DMEM read.
    assign ck_slot = (cnt == CNT_W'(DUMP_WORDS));
`else
    assign ck_slot = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trap_seen) begin
                    state_next = (TOTAL_WORDS == 0) ? DONE : READ;
                end
            end
            READ: state_next = WAIT;
            WAIT: begin
                if (lat_done) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    state_next = last_word ? DONE : READ;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            lat_cnt     <= '0;
            addr_q      <= 32'(DUMP_BASE);
            data_q      <= '0;
            dump_addr_q <= '0;
            sum         <= '0;
            halt_q      <= 1'b0;
        end else begin
            if ((state == IDLE) && trap_seen) begin
                halt_q <= 1'b1;
                cnt    <= '0;
                addr_q <= 32'(DUMP_BASE);
                sum    <= '0;
            end
            if (state == WAIT) begin
                if (lat_done) begin
                    lat_cnt     <= '0;
                    data_q      <= ck_slot ? sum : mem_rdata;
                    dump_addr_q <= addr_q;
                    if (!ck_slot) begin
                        sum <= sum + mem_rdata;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 2'd1;
                end
            end
            if (handshake) begin
                cnt    <= cnt + CNT_W'(1);
                addr_q <= addr_q + 32'(WORD_BYTES);
            end
        end
    end

    assign halt       = halt_q;
    assign mem_rd     = (state == READ) && !ck_slot;
    assign mem_addr   = mem_rd ? addr_q : 32'd0;
    assign dump_valid = (state == SEND);
    assign dump_data  = data_q;
    assign dump_addr  = dump_addr_q;
    assign dump_last  = dump_valid && last_word;
    assign done       = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_trap_dump_unit.sv
// ---- tb_trap_dump_unit | randomized bench with behavioural stream model | rev 1.0 ----
`default_nettype none

module tb_trap_dump_unit;

    localparam int          DW   = 10;
    localparam int          LAT  = 1;
    localparam int          BASE = 8192;
    localparam logic [31:0] TRAP = 32'h4400_0300;
`ifdef TRAP_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NW = DW + CK;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        halt, mem_rd, dump_valid, dump_last, done;
    logic [31:0] mem_addr, mem_rdata, dump_data, dump_addr;
    logic        dump_ready;

    logic        z_halt, z_mem_rd, z_valid, z_last, z_done;
    logic [31:0] z_mem_addr, z_data, z_addr;
    logic        z_ready;

    int checks = 0;
    int errors = 0;

    trap_dump_unit #(.DUMP_WORDS(DW), .MEM_LAT(LAT)) u_dut (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .halt(halt), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_addr(dump_addr), .dump_last(dump_last), .done(done)
    );

    trap_dump_unit #(.DUMP_WORDS(0), .MEM_LAT(LAT)) u_dut0 (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .halt(z_halt), .mem_rd(z_mem_rd), .mem_addr(z_mem_addr), .mem_rdata(mem_rdata),
        .dump_valid(z_valid), .dump_ready(z_ready), .dump_data(z_data),
        .dump_addr(z_addr), .dump_last(z_last), .done(z_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DMEM: byte array of the result region, registered read of MEM_LAT stages.
    logic [7:0]  mem_b [0:63];
    logic [31:0] p1, p2;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int o;
        o = int'(a - 32'(BASE)) & 60;
        return {mem_b[o], mem_b[o+1], mem_b[o+2], mem_b[o+3]};
    endfunction

    always @(posedge clock) begin
        p1 <= mem_rd ? word_at(mem_addr) : 32'hDEAD_BEEF;
        p2 <= p1;
    end
    assign mem_rdata = (LAT == 1) ? p1 : p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected stream queue plus cycle gap to the next valid word.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
        bit          ck;
    } ent_t;

    ent_t q[$];
    bit   halt_e, done_e, valid_e;
    int   gap;

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            halt_e  = 0;
            done_e  = 0;
            valid_e = 0;
            gap     = 0;
        end else if (!halt_e) begin
            if (instr_valid && instruction == TRAP) begin
                logic [31:0] s;
                s = 0;
                halt_e = 1;
                for (int i = 0; i < DW; i++) begin
                    logic [31:0] a, d;
                    a = 32'(BASE + 4 * i);
                    d = word_at(a);
                    s = s + d;
                    q.push_back('{a, d, (CK == 0) && (i == DW - 1), 1'b0});
                end
                if (CK != 0) q.push_back('{32'(BASE + 4 * DW), s, 1'b1, 1'b1});
                if (q.size() == 0) done_e = 1;
                else gap = 1 + LAT;
            end
        end else if (valid_e) begin
            if (dump_ready) begin
                void'(q.pop_front());
                valid_e = 0;
                if (q.size() == 0) done_e = 1;
                else gap = 1 + LAT;
            end
        end else if (gap > 0) begin
            gap--;
            if (gap == 0) valid_e = 1;
        end
    end

    // Observation log and per-cycle compare against the model.
    bit          chk_en = 0;
    int          obs_n  = 0;
    logic [31:0] obs_data [0:15];
    logic [31:0] obs_addr [0:15];
    bit          obs_last [0:15];
    int          z_words = 0, z_rd = 0;
    logic [31:0] z_last_data = 32'hFFFF_FFFF;

    always @(negedge clock) begin
        if (chk_en) begin
            bit rd_e;
            rd_e = halt_e && !valid_e && !done_e && (gap == 1 + LAT) && (q.size() > 0) && !q[0].ck;
            chk("halt", halt, halt_e);
            chk("done", done, done_e);
            chk("dump_valid", dump_valid, valid_e);
            chk("mem_rd", mem_rd, rd_e);
            if (rd_e) chk("mem_addr", mem_addr, q[0].addr);
            if (valid_e) begin
                chk("dump_data", dump_data, q[0].data);
                chk("dump_addr", dump_addr, q[0].addr);
                chk("dump_last", dump_last, q[0].last);
            end
            if (reset) begin
                obs_n   = 0;
                z_words = 0;
                z_rd    = 0;
            end else begin
                if (dump_valid && dump_ready && obs_n < 16) begin
                    obs_data[obs_n] = dump_data;
                    obs_addr[obs_n] = dump_addr;
                    obs_last[obs_n] = dump_last;
                    obs_n++;
                end
                if (z_valid) begin
                    z_words++;
                    z_last_data = z_data;
                end
                if (z_mem_rd) z_rd++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic trap_in();
        instruction = TRAP;
        instr_valid = 1'b1;
        step();
        instruction = 32'h0;
        instr_valid = 1'b0;
    endtask

    task automatic run_dump(input int stall_n);
        int n;
        int stall_left;
        n = 0;
        stall_left = stall_n;
        while (done !== 1'b1 && n < 3000) begin
            if (obs_n == 2 && dump_valid && stall_left > 0) begin
                dump_ready = 1'b0;
                stall_left--;
            end else begin
                dump_ready = ($urandom_range(0, 3) != 0);
            end
            step();
            n++;
        end
        chk("dump_completes", done, 1'b1);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        instruction = 32'h0;
        instr_valid = 1'b0;
        dump_ready  = 1'b0;
        z_ready     = 1'b1;
        for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
        mem_b[0] = 8'h00; mem_b[1] = 8'h00; mem_b[2] = 8'h01; mem_b[3] = 8'h2C;
        @(posedge clock);
        chk_en = 1;
        #1;
        step();
        step();
        reset = 1'b0;
        chk("reset_halt", halt, 1'b0);
        chk("reset_valid", dump_valid, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'h0);

        for (int i = 0; i < 3; i++) begin
            instruction = $urandom | 32'h1;
            instr_valid = 1'b1;
            step();
        end
        instruction = TRAP;
        instr_valid = 1'b0;
        step();
        instruction = 32'h0;
        step();
        chk("invalid_trap_ignored", halt, 1'b0);
        trap_in();
        chk("halt_after_trap", halt, 1'b1);

        run_dump(5);
        chk("word_count", 32'(obs_n), 32'(NW));
        chk("first_data_be", obs_data[0], 32'h0000_012C);
        chk("first_addr", obs_addr[0], 32'd8192);
        chk("tenth_addr", obs_addr[DW-1], 32'd8228);
        chk("last_flag", 32'(obs_last[NW-1]), 32'd1);
        chk("zero_dump_reads", 32'(z_rd), 32'd0);
        chk("zero_dump_words", 32'(z_words), 32'(CK));
        chk("zero_dump_done", z_done, 1'b1);
`ifdef TRAP_DUMP_CHECKSUM_EN
        chk("zero_dump_checksum", z_last_data, 32'd0);
`endif

        trap_in();
        repeat (5) step();
        chk("trap_in_done_ignored", 32'(obs_n), 32'(NW));
        chk("done_sticky", done, 1'b1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < DW; i++) begin
            mem_b[4*i] = 8'h0; mem_b[4*i+1] = 8'h0; mem_b[4*i+2] = 8'h0;
            mem_b[4*i+3] = 8'(i + 1);
        end
        trap_in();
        n = 0;
        dump_ready = 1'b1;
        while (!(obs_n == 5 && dump_valid === 1'b1) && n < 500) begin
            step();
            n++;
        end
        chk("reach_word6", 32'(obs_n), 32'd5);
        dump_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_halt", halt, 1'b0);
        chk("midreset_valid", dump_valid, 1'b0);
        chk("midreset_done", done, 1'b0);
        trap_in();
        run_dump(0);
        chk("restart_addr", obs_addr[0], 32'd8192);
        chk("restart_data0", obs_data[0], 32'd1);
        chk("restart_data9", obs_data[DW-1], 32'd10);
`ifdef TRAP_DUMP_CHECKSUM_EN
        chk("checksum_data", obs_data[DW], 32'd55);
        chk("checksum_addr", obs_addr[DW], 32'd8232);
        chk("checksum_last", 32'(obs_last[DW]), 32'd1);
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trap_dump_unit.md
Name: trap_dump_unit

Overview:
- Hardware end-of-program handler for the pipeline.
- Watches the fetched instruction stream for the trap word 0x44000300 and asserts halt to freeze the pipeline.
- Then reads DUMP_WORDS consecutive 32-bit words from DMEM starting at DUMP_BASE and streams them out on a valid/ready result port.
- It is the consuming/reader end of the program-result region that the CPU writes during execution.

Parameters:
- TRAP_WORD, 32'h44000300, instruction encoding that ends a program
- DUMP_BASE, 8192, byte address of the first result word (must be 4-aligned)
- DUMP_WORDS, 10, number of 32-bit words streamed (0 allowed)
- MEM_LAT, 1, DMEM read latency in cycles (1 or 2)

Ports:
- clock  in  1  system clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- instruction  in  [0:31]  instruction currently in fetch
- instr_valid  in  1  instruction is a real fetch, not a bubble or flush
- halt  out  1  freezes PC and pipeline registers while high
- mem_rd  out  1  DMEM read strobe
- mem_addr  out  [0:31]  DMEM byte address, word-aligned
- mem_rdata  in  [0:31]  big-endian word; {mem[a],mem[a+1],mem[a+2],mem[a+3]}
- dump_valid  out  1  dump_data/dump_addr are valid
- dump_ready  in  1  downstream accepts the word
- dump_data  out  [0:31]  result word
- dump_addr  out  [0:31]  byte address of dump_data
- dump_last  out  1  marks the final streamed word
- done  out  1  dump complete; stays high until reset

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter 0; address register = DUMP_BASE.
- Reset asserted mid-dump returns to IDLE on the next edge, drops halt, and discards any pending word.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: if instr_valid && instruction==TRAP_WORD, then halt<=1 and go to READ on the next edge.
  - A trap word with instr_valid=0 is ignored.
  - If DUMP_WORDS==0, go directly to DONE instead of READ.
- READ: mem_rd=1 for exactly one cycle with mem_addr=DUMP_BASE+4*cnt, then go to WAIT.
- WAIT: count MEM_LAT cycles, then capture mem_rdata into dump_data, set dump_addr, assert dump_valid, go to SEND.
- SEND: dump_valid, dump_data and dump_addr stay stable until the cycle where dump_valid && dump_ready.
  - On that handshake: cnt++ and dump_valid drops the next cycle (no back-to-back issue; minimum 2+MEM_LAT cycles per word).
  - If cnt was DUMP_WORDS-1, go to DONE; otherwise go to READ.
  - dump_last=1 while the final word is valid.
- DONE: done=1, halt stays 1, and further trap words are ignored. Only reset leaves DONE.
- halt is registered: it rises 1 cycle after the trap is seen and stays 1 from then until reset.
- Address arithmetic is 32-bit and wraps modulo 2^32; no bounds check.
- The counter width is sized to hold DUMP_WORDS.
- dump_ready held high: each word still takes READ+WAIT+SEND cycles.
- dump_ready low indefinitely: the block stalls in SEND with outputs stable.

Optional Feature:
- Macro: TRAP_DUMP_CHECKSUM_EN.
- Defined: after the last data word, emit one extra word.
  - dump_data = wrapping 32-bit sum of all dumped words; dump_addr = DUMP_BASE+4*DUMP_WORDS.
  - dump_last moves to this checksum word, with the same valid/ready rules.
  - If DUMP_WORDS==0, emit the checksum 0 before DONE.
- Undefined: no checksum word; behaviour exactly as above.

Decomposition:
- Package trap_dump_pkg holds:
  - the state enum (IDLE, READ, WAIT, SEND, DONE);
  - constant TRAP_OPCODE_WORD = 32'h44000300;
  - constant WORD_BYTES = 4.
- No sub-module. The FSM, counter and output register fit in one module.

Test Plan:
- Reset, then feed 3 normal instructions, then 0x44000300 with instr_valid=1 -> halt=1 one cycle later; mem_addr sequence 8192, 8196, …, 8228; 10 words streamed; dump_last on the 10th; done=1.
- Preload DMEM[8192..8195]=00 00 01 2C -> first dump_data=0x0000012C, dump_addr=8192 (big-endian byte order check).
- Toggle dump_ready low for 5 cycles during word 3 -> dump_data and dump_addr held stable, no extra mem_rd pulses, no word lost or duplicated.
- Trap word with instr_valid=0, then later a valid trap -> only the valid trap starts the dump; a second trap in DONE is ignored.
- Assert reset during word 6 -> next cycle halt=0, dump_valid=0, state IDLE; a new trap restarts the dump at 8192.
- TRAP_DUMP_CHECKSUM_EN defined, words 1..10 -> 11th word=55 with dump_addr=8232 and dump_last=1; DUMP_WORDS=0 -> single checksum word 0.
